// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop, LSB first.
// A start/busy/done handshake frames each WIDTH-cycle operation.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_nx;
    logic [CW-1:0]    cnt;
    logic             c, s, c_nx, last_bit;

    assign s        = a_sr[0] ^ b_sr[0] ^ c;
    assign c_nx     = (a_sr[0] & b_sr[0]) | (c & (a_sr[0] ^ b_sr[0]));
    assign sum_nx   = {s, sum_sr[WIDTH-1:1]};
    assign last_bit = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_bit) state_nx = S_DONE;
            end
            S_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        sum_sr <= '0;
                        c      <= cin;
                        cnt    <= '0;
                    end
                end
                S_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_nx;
                    c      <= c_nx;
                    // wrap to zero so the counter never passes WIDTH-1
                    if (last_bit) begin
                        cnt  <= '0;
                        sum  <= sum_nx;
                        cout <= c_nx;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder at WIDTH=8 and WIDTH=3.
// Expected results come from plain integer addition and fixed vectors.
module tb_bit_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start3, cin3, busy3, done3, cout3;
    logic [2:0] a3, b3, sum3;

    int checks = 0;
    int errors = 0;
    logic [8:0] last [2];

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    bit_serial_adder #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
        .cin(cin3), .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [8:0] res(input bit w3);
        return w3 ? {5'b0, cout3, sum3} : {cout8, sum8};
    endfunction

    function automatic logic get_busy(input bit w3);
        return w3 ? busy3 : busy8;
    endfunction

    function automatic logic get_done(input bit w3);
        return w3 ? done3 : done8;
    endfunction

    task automatic drive(input bit w3, input logic st, input logic [7:0] av,
                         input logic [7:0] bv, input logic ci);
        if (w3) begin
            start3 = st; a3 = av[2:0]; b3 = bv[2:0]; cin3 = ci;
        end else begin
            start8 = st; a8 = av; b8 = bv; cin8 = ci;
        end
    endtask

    // Caller is at a negedge with the DUT idle; returns one negedge after done.
    task automatic do_add(input bit w3, input logic [7:0] av,
                          input logic [7:0] bv, input logic ci,
                          input logic [8:0] exp, input string nm);
        int  w, lat;
        bit  bz_ok, hold_ok, seen;
        w = w3 ? 3 : 8;
        drive(w3, 1'b1, av, bv, ci);
        @(negedge clk);
        drive(w3, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        lat = 1; bz_ok = 1; hold_ok = 1; seen = 0;
        while (lat <= 20) begin
            if (get_busy(w3) !== 1'b1) bz_ok = 0;
            if (get_done(w3) === 1'b1) begin
                seen = 1;
                break;
            end
            if (res(w3) !== last[w3]) hold_ok = 0;
            lat++;
            @(negedge clk);
            drive(w3, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        end
        chk({nm, "_done_seen"}, 32'(seen), 32'd1);
        chk({nm, "_latency"}, 32'(lat), 32'(w + 1));
        chk({nm, "_busy"}, 32'(bz_ok), 32'd1);
        chk({nm, "_hold"}, 32'(hold_ok), 32'd1);
        chk({nm, "_result"}, 32'(res(w3)), 32'(exp));
        last[w3] = exp;
        @(negedge clk);
        chk({nm, "_done_pulse"}, 32'({get_done(w3), get_busy(w3)}), 32'd0);
    endtask

    initial begin
        vec_t tv[7];
        logic [7:0] xa, xb, a2, b2;
        logic       xc, c2;
        logic [8:0] e1, e2;
        bit         ok;

        tv[0] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};
        tv[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tv[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        tv[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tv[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        tv[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
        tv[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

        // reset with start asserted: nothing may begin
        rst = 1'b1;
        drive(1'b0, 1'b1, 8'h12, 8'h34, 1'b1);
        drive(1'b1, 1'b1, 8'h5, 8'h6, 1'b1);
        repeat (2) @(negedge clk);
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_res8", 32'(res(1'b0)), 32'd0);
        chk("rst_res3", 32'(res(1'b1)), 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h0, 8'h0, 1'b0);
        drive(1'b1, 1'b0, 8'h0, 8'h0, 1'b0);
        last[0] = '0;
        last[1] = '0;
        @(negedge clk);
        chk("rst_no_start", 32'({busy8, busy3}), 32'd0);

        for (int i = 0; i < 7; i++)
            do_add(1'b0, tv[i].a, tv[i].b, tv[i].ci,
                   {tv[i].co, tv[i].s}, $sformatf("vec%0d", i));

        for (int i = 0; i < 30; i++) begin
            xa = 8'($urandom); xb = 8'($urandom); xc = 1'($urandom);
            do_add(1'b0, xa, xb, xc, 9'(xa) + 9'(xb) + 9'(xc),
                   $sformatf("rnd%0d", i));
        end

        // start held high, operands churning mid-run
        xa = 8'h9C; xb = 8'h77; xc = 1'b1;
        e1 = 9'(xa) + 9'(xb) + 9'(xc);
        a2 = '0; b2 = '0; c2 = 1'b0;
        drive(1'b0, 1'b1, xa, xb, xc);
        ok = 1;
        for (int j = 1; j <= 19; j++) begin
            @(negedge clk);
            if (j <= 8 && (done8 !== 1'b0 || res(1'b0) !== last[0])) ok = 0;
            if (j == 9) begin
                chk("held_done1", 32'(done8), 32'd1);
                chk("held_res1", 32'(res(1'b0)), 32'(e1));
            end
            if (j == 10) chk("held_idle_gap", 32'(busy8), 32'd0);
            if (j == 11) chk("held_second_accept", 32'(busy8), 32'd1);
            if (j >= 10 && j <= 18 && (done8 !== 1'b0 || res(1'b0) !== e1))
                ok = 0;
            if (j == 19) begin
                chk("held_done2", 32'(done8), 32'd1);
                chk("held_res2", 32'(res(1'b0)), 32'(e2));
            end
            drive(1'b0, j != 19, 8'($urandom), 8'($urandom), 1'($urandom));
            if (j == 10) begin
                a2 = a8; b2 = b8; c2 = cin8;
                e2 = 9'(a2) + 9'(b2) + 9'(c2);
            end
        end
        chk("held_stable", 32'(ok), 32'd1);
        last[0] = e2;
        @(negedge clk);

        // reset in the middle of an add
        do_add(1'b0, 8'h12, 8'h34, 1'b0, 9'h046, "pre_abort");
        drive(1'b0, 1'b1, 8'h0F, 8'h01, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h0, 8'h0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs", 32'({busy8, done8, res(1'b0)}), 32'd0);
        rst = 1'b0;
        last[0] = '0;
        last[1] = '0;
        ok = 1;
        repeat (12) begin
            @(negedge clk);
            if (done8 !== 1'b0 || busy8 !== 1'b0) ok = 0;
        end
        chk("abort_no_done", 32'(ok), 32'd1);
        do_add(1'b0, 8'hC8, 8'h64, 1'b1, 9'h12D, "post_abort");

        // WIDTH=3 exhaustive
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                for (int z = 0; z < 2; z++)
                    do_add(1'b1, 8'(x), 8'(y), 1'(z), 9'(x + y + z),
                           $sformatf("w3_%0d_%0d_%0d", x, y, z));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
